// File: rtl/product_price_calc_pkg.sv
// Shared definitions for the scale pricing path: product codes, price table,
// FSM state encoding and the rounding/divide constants.
package product_price_calc_pkg;

    typedef logic [2:0]  prod_code_t;
    typedef logic [12:0] cents_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT_W = 3'd1,
        ST_MUL    = 3'd2,
        ST_DIV    = 3'd3,
        ST_OUT    = 3'd4,
        ST_HOLD   = 3'd5
    } state_e;

    localparam prod_code_t  PROD_NONE    = 3'd0;
    localparam logic [21:0] ROUND_OFFSET = 22'd500;
    localparam logic [10:0] DIVISOR      = 11'd1000;
    localparam logic [4:0]  DIV_ITERS    = 5'd22;

    function automatic logic [9:0] price_lookup(input prod_code_t code);
        logic [9:0] p;
        case (code)
            3'd1:    p = 10'd129;
            3'd2:    p = 10'd249;
            3'd3:    p = 10'd299;
            3'd4:    p = 10'd450;
            3'd5:    p = 10'd199;
            3'd6:    p = 10'd899;
            3'd7:    p = 10'd1023;
            default: p = 10'd0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/product_price_calc_if.sv
// Result handshake from the pricing block to the display/receipt stage.
interface product_price_calc_if;
    import product_price_calc_pkg::*;

    logic       total_valid;
    logic       total_ready;
    cents_t     total_cents;
    prod_code_t total_product;

    modport master (output total_valid, output total_cents, output total_product, input total_ready);
    modport slave  (input total_valid, input total_cents, input total_product, output total_ready);
endinterface

// File: rtl/product_price_calc_divider.sv
// Restoring shift-subtract divider by the fixed price divisor: one quotient bit
// per cycle, the first bit is resolved on the start edge itself.
module price_divider
    import product_price_calc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [21:0] dividend,
    output cents_t      quotient,
    output logic        done
);

    logic [9:0]  rem_r;
    logic [21:0] quo_r;
    logic [4:0]  cnt_r;
    logic        done_r;
    logic [9:0]  rem_in_s;
    logic [21:0] quo_in_s;
    logic [10:0] trial_s;
    logic [9:0]  rem_nxt_s;
    logic [21:0] quo_nxt_s;

    // One restoring step, applied to a freshly loaded dividend or the running state
    always_comb begin
        rem_in_s = rem_r;
        quo_in_s = quo_r;
        if (start) begin
            rem_in_s = 10'd0;
            quo_in_s = dividend;
        end else begin
            rem_in_s = rem_r;
            quo_in_s = quo_r;
        end
        trial_s = {rem_in_s, quo_in_s[21]};
        if (trial_s >= DIVISOR) begin
            rem_nxt_s = 10'(trial_s - DIVISOR);
            quo_nxt_s = {quo_in_s[20:0], 1'b1};
        end else begin
            rem_nxt_s = trial_s[9:0];
            quo_nxt_s = {quo_in_s[20:0], 1'b0};
        end
    end

    // Iteration counter and registered done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r  <= 10'd0;
            quo_r  <= 22'd0;
            cnt_r  <= 5'd0;
            done_r <= 1'b0;
        end else if (start) begin
            rem_r  <= rem_nxt_s;
            quo_r  <= quo_nxt_s;
            cnt_r  <= DIV_ITERS - 5'd1;
            done_r <= 1'b0;
        end else if (cnt_r != 5'd0) begin
            rem_r  <= rem_nxt_s;
            quo_r  <= quo_nxt_s;
            cnt_r  <= cnt_r - 5'd1;
            done_r <= (cnt_r == 5'd1);
        end else begin
            done_r <= 1'b0;
        end
    end

    // The quotient never exceeds 13 bits for legal price x weight products
    assign quotient = quo_r[12:0];
    assign done     = done_r;

endmodule

// File: rtl/product_price_calc.sv
// Debounces the classifier code, captures one weight sample and prices the item
// in cents with round-half-up, presenting the result on a valid/ready handshake.
module product_price_calc
    import product_price_calc_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  prod_code_t           product_detected,
    input  logic [11:0]          weight_g,
    input  logic                 weight_valid,
    output logic                 busy,
    product_price_calc_if.master res
);

    // The match that lifts the run to STABLE_CYCLES samples is the confirming one
    localparam logic [7:0] CONFIRM_AT = 8'(STABLE_CYCLES - 2);

    state_e      state_r;
    prod_code_t  prev_r;
    logic [7:0]  stab_cnt_r;
    logic [11:0] weight_r;
    logic        total_valid_r;
    cents_t      total_cents_r;
    prod_code_t  total_product_r;
    logic        busy_r;
    logic        div_start_s;
    logic [21:0] dividend_s;
    cents_t      div_quot_s;
    logic        div_done_s;

    assign div_start_s = (state_r == ST_MUL);
    assign dividend_s  = ({12'd0, price_lookup(total_product_r)} * {10'd0, weight_r}) + ROUND_OFFSET;

    price_divider u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_s),
        .dividend (dividend_s),
        .quotient (div_quot_s),
        .done     (div_done_s)
    );

    // Main control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            prev_r          <= PROD_NONE;
            stab_cnt_r      <= 8'd0;
            weight_r        <= 12'd0;
            total_valid_r   <= 1'b0;
            total_cents_r   <= 13'd0;
            total_product_r <= PROD_NONE;
            busy_r          <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    prev_r <= product_detected;
                    if ((product_detected == prev_r) && (product_detected != PROD_NONE)) begin
                        if (stab_cnt_r == CONFIRM_AT) begin
                            stab_cnt_r      <= CONFIRM_AT + 8'd1;
                            total_product_r <= product_detected;
                            state_r         <= ST_WAIT_W;
                        end else begin
                            stab_cnt_r <= stab_cnt_r + 8'd1;
                        end
                    end else begin
                        stab_cnt_r <= 8'd0;
                    end
                end
                ST_WAIT_W: begin
                    // A weight strobe wins over a simultaneous code change
                    if (weight_valid) begin
                        weight_r <= weight_g;
                        busy_r   <= 1'b1;
                        state_r  <= ST_MUL;
                    end else if (product_detected != total_product_r) begin
                        stab_cnt_r <= 8'd0;
                        state_r    <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT_W;
                    end
                end
                ST_MUL: begin
                    state_r <= ST_DIV;
                end
                ST_DIV: begin
                    if (div_done_s) begin
                        total_cents_r <= div_quot_s;
                        total_valid_r <= 1'b1;
                        state_r       <= ST_OUT;
                    end else begin
                        state_r <= ST_DIV;
                    end
                end
                ST_OUT: begin
                    if (res.total_ready) begin
                        total_valid_r <= 1'b0;
                        busy_r        <= 1'b0;
                        state_r       <= ST_HOLD;
                    end else begin
                        state_r <= ST_OUT;
                    end
                end
                ST_HOLD: begin
                    // Item must leave the scale before another one can be billed
                    if ((product_detected == PROD_NONE) || (product_detected != total_product_r)) begin
                        stab_cnt_r <= 8'd0;
                        state_r    <= ST_IDLE;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign res.total_valid   = total_valid_r;
    assign res.total_cents   = total_cents_r;
    assign res.total_product = total_product_r;
    assign busy              = busy_r;

endmodule
